// File: rtl/spi_pkg.sv
// Shared FSM state encoding and SPI mode constants for the frame slave.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } spi_state_t;

  localparam int unsigned CPOL_IDLE_LOW     = 0;
  localparam int unsigned CPOL_IDLE_HIGH    = 1;
  localparam int unsigned CPHA_SAMPLE_LEAD  = 0;
  localparam int unsigned CPHA_SAMPLE_TRAIL = 1;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous input with rise/fall strobes.
module spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= {SYNC_STAGES{RESET_VAL}};
      r_prev <= RESET_VAL;
    end else begin
      r_sync[0] <= i_async;
      for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
        r_sync[k] <= r_sync[k-1];
      end
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign level = r_sync[SYNC_STAGES-1];
  assign rise  = level & ~r_prev;
  assign fall  = ~level & r_prev;

endmodule

// File: rtl/spi_frame_slave.sv
// SPI slave receiving a fixed-length MOSI frame and returning a buffered MISO word,
// fully oversampled in the clk domain.
module spi_frame_slave
  import spi_pkg::*;
#(
  parameter int unsigned MOSI_W      = 768,
  parameter int unsigned MISO_W      = 256,
  parameter int unsigned CPOL        = 0,
  parameter int unsigned CPHA        = 0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  input  logic [MISO_W-1:0] tx_data,
  input  logic              tx_load,
  output logic              tx_ready,
  output logic [MOSI_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              frame_err
);

  localparam int unsigned     CW   = $clog2(MOSI_W + 1);
  localparam logic [CW-1:0]   LAST = CW'(MOSI_W - 1);

  spi_state_t r_state, w_state_nxt;

  logic              w_sclk_lvl, w_sclk_rise, w_sclk_fall;
  logic              w_cs_lvl, w_cs_rise, w_cs_fall;
  logic              w_mosi, w_mosi_rise, w_mosi_fall;
  logic              w_lead, w_trail, w_sample, w_drive, w_enter;
  logic [MOSI_W-1:0] w_rx_next;
  logic [MISO_W-1:0] w_tx_word;
  logic              w_unused;

  logic [MOSI_W-1:0] r_rx_sr, r_rx_data;
  logic [MISO_W-1:0] r_tx_buf, r_tx_sr;
  logic [CW-1:0]     r_bit_cnt;
  logic              r_miso, r_rx_valid, r_frame_err;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'(CPOL))) u_sync_sclk (
    .clk(clk), .rst(rst), .i_async(sclk),
    .level(w_sclk_lvl), .rise(w_sclk_rise), .fall(w_sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst(rst), .i_async(cs_n),
    .level(w_cs_lvl), .rise(w_cs_rise), .fall(w_cs_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .i_async(mosi),
    .level(w_mosi), .rise(w_mosi_rise), .fall(w_mosi_fall)
  );

  assign w_unused = ^{w_sclk_lvl, w_cs_lvl, w_mosi_rise, w_mosi_fall};

  assign w_lead    = (CPOL == CPOL_IDLE_LOW) ? w_sclk_rise : w_sclk_fall;
  assign w_trail   = (CPOL == CPOL_IDLE_LOW) ? w_sclk_fall : w_sclk_rise;
  assign w_sample  = (CPHA == CPHA_SAMPLE_LEAD) ? w_lead : w_trail;
  assign w_drive   = (CPHA == CPHA_SAMPLE_LEAD) ? w_trail : w_lead;
  assign w_enter   = (r_state == ST_IDLE) && w_cs_fall;
  assign w_rx_next = {r_rx_sr[MOSI_W-2:0], w_mosi};
  // A load coinciding with frame start must be the word that goes out.
  assign w_tx_word = tx_load ? tx_data : r_tx_buf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (w_cs_fall) w_state_nxt = ST_SHIFT;
      ST_SHIFT: if (w_sample && (r_bit_cnt == LAST)) w_state_nxt = ST_HOLD;
      ST_HOLD:  w_state_nxt = ST_HOLD;
      default:  w_state_nxt = ST_IDLE;
    endcase
    if (w_cs_rise) w_state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_sr     <= '0;
      r_rx_data   <= '0;
      r_tx_buf    <= '0;
      r_tx_sr     <= '0;
      r_bit_cnt   <= '0;
      r_miso      <= 1'b0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      if (tx_load && (r_state == ST_IDLE)) r_tx_buf <= tx_data;

      // cs_n release wins over any coincident sclk edge.
      if (w_cs_rise) begin
        r_miso <= 1'b0;
        if (r_state == ST_SHIFT) r_frame_err <= 1'b1;
      end else if (w_enter) begin
        r_bit_cnt <= '0;
        if (CPHA == CPHA_SAMPLE_LEAD) begin
          r_miso  <= w_tx_word[MISO_W-1];
          r_tx_sr <= w_tx_word << 1;
        end else begin
          r_miso  <= 1'b0;
          r_tx_sr <= w_tx_word;
        end
      end else if (r_state == ST_SHIFT) begin
        if (w_sample) begin
          r_rx_sr   <= w_rx_next;
          r_bit_cnt <= r_bit_cnt + CW'(1);
          if (r_bit_cnt == LAST) begin
            r_rx_data  <= w_rx_next;
            r_rx_valid <= 1'b1;
          end
        end
        if (w_drive) begin
          r_miso  <= r_tx_sr[MISO_W-1];
          r_tx_sr <= r_tx_sr << 1;
        end
      end
    end
  end

  assign miso      = r_miso;
  assign tx_ready  = (r_state == ST_IDLE);
  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_frame_err;

endmodule
